// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between IF and MEM with grant lock and in-order response routing
module sram_req_arbiter #(
  parameter int OST_LOG2 = 1,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [WIDTH-1:0] inst_addr,
  input  logic [WIDTH-1:0] inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [WIDTH-1:0] inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [WIDTH-1:0] data_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             ost_full,
  output logic             ost_empty,
  output logic             arb_err
);
  localparam int DEPTH = 2 ** OST_LOG2;
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;
  state_t state, state_nxt;
  logic [DEPTH-1:0]    ids;
  logic [OST_LOG2-1:0] rd_ptr, wr_ptr;
  logic [OST_LOG2:0]   count;
  logic sel_i, sel_d, hs, pop, head;
  assign sel_d = (state == LOCK_D) | ((state == IDLE) & data_req);
  assign sel_i = (state == LOCK_I) | ((state == IDLE) & !data_req & inst_req);
  assign ost_full  = count == (OST_LOG2 + 1)'(DEPTH);
  assign ost_empty = count == '0;
  assign mem_req   = !reset & !ost_full & (sel_d ? data_req : sel_i & inst_req);
  assign mem_wr    = sel_d ? data_wr    : sel_i ? inst_wr    : 1'b0;
  assign mem_size  = sel_d ? data_size  : sel_i ? inst_size  : 2'd0;
  assign mem_wstrb = sel_d ? data_wstrb : sel_i ? inst_wstrb : 4'd0;
  assign mem_addr  = sel_d ? data_addr  : sel_i ? inst_addr  : '0;
  assign mem_wdata = sel_d ? data_wdata : sel_i ? inst_wdata : '0;
  assign hs           = mem_req & mem_addr_ok;
  assign inst_addr_ok = hs & sel_i;
  assign data_addr_ok = hs & sel_d;
  assign head         = ids[rd_ptr];
  assign pop          = mem_data_ok & !ost_empty;
  assign inst_data_ok = pop & !head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  // lock the grant from request until the address handshake
  always_comb begin
    state_nxt = state;
    state_nxt = hs ? IDLE : ((state == IDLE) & mem_req) ? (sel_d ? LOCK_D : LOCK_I) : state;
  end
  // lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // in-order requester ID FIFO and sticky error on an unmatched response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ids     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      arb_err <= 1'b0;
    end else begin
      if (hs) begin
        ids[wr_ptr] <= sel_d;
        wr_ptr      <= wr_ptr + OST_LOG2'(1);
      end
      if (pop) rd_ptr <= rd_ptr + OST_LOG2'(1);
      count   <= count + (OST_LOG2 + 1)'(hs) - (OST_LOG2 + 1)'(pop);
      arb_err <= arb_err | (mem_data_ok & ost_empty);
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed checks of priority, lock, ordering, wrap and error handling
module tb_sram_req_arbiter;
  logic clk = 1'b0, reset;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size, mem_size;
  logic [3:0] inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, inst_rdata, data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, ost_full, ost_empty, arb_err;
  int n_chk = 0, n_err = 0;
  logic exp_head;
  logic [5:0] pat = 6'b101100;
  always #5 clk = ~clk;
  sram_req_arbiter #(.OST_LOG2(1), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ost_full(ost_full), .ost_empty(ost_empty), .arb_err(arb_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask
  initial begin
    reset = 1; idle_in();
    inst_wr = 0; inst_size = 2; inst_wstrb = 4'h0; inst_addr = 32'h1c000000; inst_wdata = 32'h0;
    data_wr = 1; data_size = 2; data_wstrb = 4'hf; data_addr = 32'h00001000; data_wdata = 32'hdeadbeef;
    mem_rdata = 0;
    inst_req = 1; mem_addr_ok = 1;
    #2;
    chk("rst_empty", ost_empty, 1);
    chk("rst_full", ost_full, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_iaok", inst_addr_ok, 0);
    chk("rst_err", arb_err, 0);
    tick(); tick();
    reset = 0; idle_in();
    tick();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    #1;
    chk("pri_daok", data_addr_ok, 1);
    chk("pri_iaok", inst_addr_ok, 0);
    chk("pri_addr", mem_addr, 32'h00001000);
    chk("pri_wr", mem_wr, 1);
    chk("pri_wstrb", mem_wstrb, 4'hf);
    tick();
    data_req = 0;
    #1;
    chk("pri2_iaok", inst_addr_ok, 1);
    chk("pri2_addr", mem_addr, 32'h1c000000);
    tick();
    idle_in();
    #1;
    chk("pri_full", ost_full, 1);
    mem_data_ok = 1; mem_rdata = 32'h11;
    #1;
    chk("pri_ret1_d", data_data_ok, 1);
    chk("pri_ret1_i", inst_data_ok, 0);
    chk("pri_ret1_rd", data_rdata, 32'h11);
    tick();
    mem_rdata = 32'h22;
    #1;
    chk("pri_ret2_i", inst_data_ok, 1);
    chk("pri_ret2_d", data_data_ok, 0);
    tick();
    idle_in();
    #1;
    chk("pri_empty", ost_empty, 1);
    inst_req = 1;
    #1;
    chk("lock_c1_req", mem_req, 1);
    chk("lock_c1_addr", mem_addr, 32'h1c000000);
    tick();
    data_req = 1;
    #1;
    chk("lock_c2_addr", mem_addr, 32'h1c000000);
    chk("lock_c2_daok", data_addr_ok, 0);
    tick();
    #1;
    chk("lock_c3_addr", mem_addr, 32'h1c000000);
    tick();
    mem_addr_ok = 1;
    #1;
    chk("lock_c4_iaok", inst_addr_ok, 1);
    chk("lock_c4_daok", data_addr_ok, 0);
    tick();
    inst_req = 0;
    #1;
    chk("lock_c5_daok", data_addr_ok, 1);
    chk("lock_c5_addr", mem_addr, 32'h00001000);
    tick();
    data_req = 0; inst_req = 1;
    #1;
    chk("ord_full", ost_full, 1);
    chk("ord_hold_req", mem_req, 0);
    chk("ord_hold_iaok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hAAAA5555;
    #1;
    chk("ord_ret_i", inst_data_ok, 1);
    chk("ord_ret_d", data_data_ok, 0);
    chk("ord_ret_rd", inst_rdata, 32'hAAAA5555);
    chk("ord_still_held", mem_req, 0);
    tick();
    mem_rdata = 32'h12345678;
    #1;
    chk("pp_req", mem_req, 1);
    chk("pp_iaok", inst_addr_ok, 1);
    chk("pp_ret_d", data_data_ok, 1);
    chk("pp_ret_i", inst_data_ok, 0);
    chk("pp_rd", data_rdata, 32'h12345678);
    tick();
    #1;
    chk("pp_not_empty", ost_empty, 0);
    chk("pp_not_full", ost_full, 0);
    exp_head = 0;
    for (int i = 0; i < 6; i++) begin
      inst_req = !pat[i]; data_req = pat[i]; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'(i);
      #1;
      chk($sformatf("wrap%0d_aok", i), pat[i] ? data_addr_ok : inst_addr_ok, 1);
      chk($sformatf("wrap%0d_iok", i), inst_data_ok, !exp_head);
      chk($sformatf("wrap%0d_dok", i), data_data_ok, exp_head);
      exp_head = pat[i];
      tick();
    end
    idle_in(); mem_data_ok = 1;
    #1;
    chk("drain_iok", inst_data_ok, !exp_head);
    chk("drain_dok", data_data_ok, exp_head);
    tick();
    #1;
    chk("drain_empty", ost_empty, 1);
    chk("pre_err", arb_err, 0);
    #1;
    chk("spur_iok", inst_data_ok, 0);
    chk("spur_dok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    #1;
    chk("spur_err", arb_err, 1);
    tick(); tick();
    chk("spur_err_hold", arb_err, 1);
    inst_req = 1; mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0;
    #1;
    chk("mid_cnt1", ost_empty, 0);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_empty", ost_empty, 1);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_err", arb_err, 0);
    tick();
    reset = 0; idle_in(); mem_data_ok = 1;
    #1;
    chk("post_rst_iok", inst_data_ok, 0);
    chk("post_rst_dok", data_data_ok, 0);
    tick();
    idle_in();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
